// File: rtl/router_pkg.sv
// Shared types for the router receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    // One FIFO entry: payload byte plus end-of-packet marker.
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// First-word-fall-through FIFO holding received bytes with their last flag.
// Latency: a write is visible at the head one cycle after the write edge.
// Backpressure: caller must not write when full unless popping in the same cycle.
module router_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Storage array; contents need no reset since empty gates the head.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_dat = mem[rd_ptr[AW-1:0]];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/router_port_rx.sv
// Deserialises one router output port (LSB-first bits) into bytes queued in a FIFO.
// Latency: byte visible on valid_o one cycle after the edge accepting its 8th bit.
// Backpressure: ready_i pops the head; bytes completing while full with no pop are dropped (overflow_o).
module router_port_rx
    import router_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              dout,
    input  logic              valido_n,
    input  logic              frameo_n,
    output logic [BYTE_W-1:0] byte_o,
    output logic              last_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overflow_o,
    output logic              frag_err_o,
    output logic [CNT_W-1:0]  pkt_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    rx_state_e         state;
    rx_state_e         state_nxt;
    logic              armed;      // frameo_n seen high since reset
    logic [2:0]        bit_idx;
    logic [BYTE_W-2:0] shreg;      // bits 0..6 of the byte in progress
    logic              accept;
    logic              eop;
    logic              byte_done;
    logic              pkt_ok;
    logic              pkt_frag;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;
    rx_entry_t         wr_entry;
    rx_entry_t         head;

    // Next-state and bit-accept decode; a frame start is only honoured once armed.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        eop       = 1'b0;
        case (state)
            IDLE: begin
                accept = !valido_n && !frameo_n && armed;
                if (!frameo_n && armed) state_nxt = RECV;
            end
            RECV: begin
                accept = !valido_n;
                eop    = frameo_n;
                if (frameo_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign byte_done = accept && (bit_idx == 3'd7);
    assign pkt_ok    = eop && (accept ? (bit_idx == 3'd7) : (bit_idx == 3'd0));
    assign pkt_frag  = eop && !pkt_ok;
    assign pop       = !fifo_empty && ready_i;
    assign wr_en     = byte_done && (!fifo_full || pop);
    assign drop      = byte_done && fifo_full && !pop;
    assign wr_entry  = '{last: frameo_n, data: {dout, shreg}};

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Shifter, bit index, sticky flags and packet counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            armed      <= 1'b0;
            bit_idx    <= 3'd0;
            shreg      <= '0;
            overflow_o <= 1'b0;
            frag_err_o <= 1'b0;
            pkt_cnt_o  <= '0;
        end else begin
            armed <= armed | frameo_n;
            if (eop)         bit_idx <= 3'd0;
            else if (accept) bit_idx <= bit_idx + 3'd1;
            if (accept && (bit_idx != 3'd7)) shreg[bit_idx] <= dout;
            if (drop)     overflow_o <= 1'b1;
            if (pkt_frag) frag_err_o <= 1'b1;
            if (pkt_ok)   pkt_cnt_o  <= pkt_cnt_o + CNT_ONE;
        end
    end

    router_rx_fifo #(
        .DEPTH (DEPTH),
        .W     (BYTE_W + 1)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_dat  (wr_entry),
        .rd_en   (pop),
        .rd_dat  (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign valid_o = !fifo_empty;
    assign byte_o  = fifo_empty ? '0 : head.data;
    assign last_o  = fifo_empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_router_port_rx.sv
module tb_router_port_rx;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        dout;
    logic        valido_n;
    logic        frameo_n;
    logic [7:0]  byte_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i;
    logic        overflow_o;
    logic        frag_err_o;
    logic [15:0] pkt_cnt_o;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q [$];      // {last, byte}
    logic [7:0] pkt_buf [16];

    always #5 clock = ~clock;

    router_port_rx #(.DEPTH(8), .CNT_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .dout       (dout),
        .valido_n   (valido_n),
        .frameo_n   (frameo_n),
        .byte_o     (byte_o),
        .last_o     (last_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o),
        .frag_err_o (frag_err_o),
        .pkt_cnt_o  (pkt_cnt_o)
    );

    // Monitor: every accepted head byte is compared against the scoreboard.
    always @(negedge clock) begin
        if (reset_n && valid_o && ready_i) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL out_unexpected: got byte=%02h last=%0b, scoreboard empty", byte_o, last_o);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({last_o, byte_o} !== e) begin
                    errors = errors + 1;
                    $display("FAIL out_byte: got byte=%02h last=%0b, want byte=%02h last=%0b",
                             byte_o, last_o, e[7:0], e[8]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] b, input logic last);
        exp_q.push_back({last, b});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valido_n = 1'b1;
            frameo_n = 1'b1;
            dout     = 1'b0;
            tick();
        end
    endtask

    // Sends nbits from pkt_buf, LSB first; optional valid gaps of 1..3 cycles.
    task automatic send_pkt(input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && (i == 3 || i == 8 || i == 13)) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    valido_n = 1'b1;
                    frameo_n = 1'b0;
                    tick();
                end
            end
            dout     = pkt_buf[i / 8][i % 8];
            valido_n = 1'b0;
            frameo_n = (i == nbits - 1);
            tick();
        end
        valido_n = 1'b1;
        frameo_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        dout     = 1'b0;
        valido_n = 1'b1;
        frameo_n = 1'b1;
        ready_i  = 1'b1;
        tick();
        tick();
        check("rst_valid", valid_o, 0);
        check("rst_byte", byte_o, 0);
        check("rst_last", last_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_frag", frag_err_o, 0);
        check("rst_cnt", pkt_cnt_o, 0);
        reset_n = 1'b1;
        idle(2);

        // 3-byte packet with consumer always ready
        pkt_buf[0] = 8'hA5; pkt_buf[1] = 8'h3C; pkt_buf[2] = 8'hFF;
        push_exp(8'hA5, 0); push_exp(8'h3C, 0); push_exp(8'hFF, 1);
        send_pkt(24, 0);
        idle(3);
        wait_drain("t1_drain");
        check("t1_cnt", pkt_cnt_o, 1);
        check("t1_frag", frag_err_o, 0);
        check("t1_ovf", overflow_o, 0);

        // 2-byte packet gap-free, then identical packet with valid gaps
        pkt_buf[0] = 8'h12; pkt_buf[1] = 8'h34;
        push_exp(8'h12, 0); push_exp(8'h34, 1);
        send_pkt(16, 0);
        idle(2);
        push_exp(8'h12, 0); push_exp(8'h34, 1);
        send_pkt(16, 1);
        idle(3);
        wait_drain("t2_drain");
        check("t2_cnt", pkt_cnt_o, 3);

        // 12-bit packet: one full byte, partial nibble discarded
        pkt_buf[0] = 8'h5A; pkt_buf[1] = 8'h07;
        push_exp(8'h5A, 0);
        send_pkt(12, 0);
        idle(3);
        wait_drain("t3_drain");
        check("t3_frag", frag_err_o, 1);
        check("t3_cnt", pkt_cnt_o, 3);
        check("t3_ovf", overflow_o, 0);

        // 10-byte packet into a stalled 8-deep FIFO
        ready_i = 1'b0;
        for (int k = 0; k < 10; k++) pkt_buf[k] = 8'h10 + 8'(k);
        for (int k = 0; k < 8; k++) push_exp(8'h10 + 8'(k), 0);
        send_pkt(80, 0);
        idle(3);
        check("t4_ovf", overflow_o, 1);
        check("t4_cnt", pkt_cnt_o, 4);
        check("t4_valid", valid_o, 1);
        check("t4_head", byte_o, 8'h10);
        ready_i = 1'b1;
        wait_drain("t4_drain");
        check("t4_empty", valid_o, 0);

        // Fresh reset, then fill exactly and complete a byte while popping
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle(2);
        check("t5_rst_ovf", overflow_o, 0);
        ready_i = 1'b0;
        for (int k = 0; k < 8; k++) pkt_buf[k] = 8'h20 + 8'(k);
        for (int k = 0; k < 7; k++) push_exp(8'h20 + 8'(k), 0);
        push_exp(8'h27, 1);
        send_pkt(64, 0);
        idle(2);
        check("t5_full_ovf", overflow_o, 0);
        push_exp(8'h28, 1);
        for (int i = 0; i < 8; i++) begin
            dout     = 8'h28 >> i;
            valido_n = 1'b0;
            frameo_n = (i == 7);
            ready_i  = (i == 7);
            tick();
        end
        valido_n = 1'b1;
        frameo_n = 1'b1;
        check("t5_ovf", overflow_o, 0);
        idle(2);
        wait_drain("t5_drain");
        check("t5_cnt", pkt_cnt_o, 2);

        // Reset mid-byte with the frame still asserted across release
        pkt_buf[0] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            dout = 1'b1; valido_n = 1'b0; frameo_n = 1'b0;
            tick();
        end
        reset_n = 1'b0;
        tick();
        tick();
        check("t6_valid", valid_o, 0);
        check("t6_byte", byte_o, 0);
        check("t6_last", last_o, 0);
        check("t6_ovf", overflow_o, 0);
        check("t6_frag", frag_err_o, 0);
        check("t6_cnt", pkt_cnt_o, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dout = 1'b1; valido_n = 1'b0; frameo_n = 1'b0;
            tick();
        end
        idle(2);
        check("t6_ignored_valid", valid_o, 0);
        check("t6_ignored_cnt", pkt_cnt_o, 0);
        check("t6_ignored_frag", frag_err_o, 0);
        pkt_buf[0] = 8'h81;
        push_exp(8'h81, 1);
        send_pkt(8, 0);
        idle(3);
        wait_drain("t6_drain");
        check("t6_cnt_after", pkt_cnt_o, 1);
        check("t6_frag_after", frag_err_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_port_rx.md
ROUTER_PORT_RX -- requirements
Module: router_port_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, byte FIFO depth (power of two, 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of packet counter.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port dout  input  1  serial data bit from one router output port, LSB first.
REQ-006 SHALL have port valido_n  input  1  active-low: dout valid this cycle.
REQ-007 SHALL have port frameo_n  input  1  active-low packet frame; deasserts coincident with last valid bit.
REQ-008 SHALL have port byte_o  output  8  head-of-FIFO byte.
REQ-009 SHALL have port last_o  output  1  head byte is final byte of its packet.
REQ-010 SHALL have port valid_o  output  1  byte_o/last_o valid.
REQ-011 SHALL have port ready_i  input  1  consumer accepts head byte when valid_o && ready_i.
REQ-012 SHALL have port overflow_o  output  1  sticky: a completed byte was dropped because FIFO full.
REQ-013 SHALL have port frag_err_o  output  1  sticky: packet ended with bit count not a multiple of 8.
REQ-014 SHALL have port pkt_cnt_o  output  CNT_W  count of packets ended cleanly, wraps at 2^CNT_W.

Function
REQ-015 SHALL sample dout, valido_n, frameo_n directly on each rising clock edge, no input synchronizer.
REQ-016 SHALL implement states IDLE and RECV; IDLE->RECV when frameo_n==0; RECV->IDLE when frameo_n==1.
REQ-017 SHALL accept a bit in any cycle with valido_n==0 and either state RECV or frameo_n==0; bits with valido_n==1 ignored.
REQ-018 SHALL shift accepted bits into byte position bit_idx (0..7), first accepted bit = bit 0.
REQ-019 SHALL, on the 8th accepted bit, write the completed byte to the FIFO at that same edge; valid_o rises the following cycle (latency 1 cycle from 8th bit edge).
REQ-020 SHALL set last=1 on a byte whose 8th bit is accepted with frameo_n==1 (end of packet), else last=0.
REQ-021 SHALL, at end of packet (RECV and frameo_n==1) with bit_idx==0 after accounting for a final accepted bit, increment pkt_cnt_o by 1 (wrap 2^CNT_W-1 -> 0).
REQ-022 SHALL, at end of packet with partial byte pending (bit_idx!=0), discard the partial byte, set frag_err_o, not increment pkt_cnt_o, and not retro-mark the previous byte as last.
REQ-023 SHALL reset bit_idx to 0 on every RECV->IDLE transition.
REQ-024 SHALL pop the head entry on valid_o && ready_i; byte_o/last_o hold stable while valid_o && !ready_i.
REQ-025 SHALL, when a write and pop occur in the same cycle with FIFO full, perform both and not flag overflow.
REQ-026 SHALL, when a write occurs with FIFO full and no pop, drop the byte, set overflow_o, leave FIFO contents unchanged, and still count the packet per REQ-021.
REQ-027 SHALL keep frag_err_o and overflow_o set until reset.
REQ-028 SHALL deassert valid_o when FIFO empty; byte_o/last_o then don't-care.

Reset
REQ-029 SHALL, when reset_n==0 at a rising edge, set state IDLE, bit_idx 0, FIFO empty, valid_o 0, last_o 0, byte_o 0, overflow_o 0, frag_err_o 0, pkt_cnt_o 0.
REQ-030 SHALL abandon any packet in progress on reset, with no partial byte, no error flag and no count.
REQ-031 SHALL, after reset release, ignore a packet already in progress (frameo_n==0 at first sampled edge) until frameo_n is seen high.

Structure
REQ-032 SHALL take rx_state_e (IDLE, RECV) and BYTE_W=8 from shared package router_pkg.
REQ-033 SHALL instantiate one sub-module router_rx_fifo (first-word-fall-through, DEPTH x 9 bits: byte + last).
REQ-034 SHALL hold the serial-to-parallel shifter, state machine, flags and counter in router_port_rx.

Verification
REQ-035 SHALL cover: 3-byte packet 0xA5,0x3C,0xFF, ready_i=1 -> bytes in order, last_o only on 0xFF, pkt_cnt_o=1.
REQ-036 SHALL cover: valido_n gaps of 1-3 cycles inside a 2-byte packet -> identical bytes to gap-free case.
REQ-037 SHALL cover: packet ends after 12 bits -> one byte output with last_o=0, frag_err_o=1, pkt_cnt_o unchanged.
REQ-038 SHALL cover: ready_i=0, 10-byte packet, DEPTH=8 -> 8 bytes retained, overflow_o=1, pkt_cnt_o=1.
REQ-039 SHALL cover: FIFO full, byte completes with ready_i=1 same cycle -> no overflow, order preserved.
REQ-040 SHALL cover: reset_n=0 mid-byte of packet -> all outputs per REQ-029; next clean 1-byte packet counted as 1.
